// File: rtl/sa_ram_rd_stream_32x256.sv
// Burst read engine for the 32x256 SA buffer RAM: issues one read per word,
// absorbs the one-cycle RAM read latency and streams words out through a 2-entry skid FIFO.
module sa_ram_rd_stream_32x256 #(
    parameter int AW   = 5,
    parameter int DW   = 256,
    parameter int SKID = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    output logic          out_last,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr, remaining, ra_q;
    logic          inflight, inflight_last;
    logic [DW:0]   fifo_mem [SKID];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occ;
    logic [DW:0]   head;
    logic          pop, push, issue, accept;

    assign pop    = out_pvld & out_prdy;
    assign push   = inflight;
    assign accept = cmd_valid & cmd_ready;

    // Credit: words buffered plus in flight, net of this cycle's pop, must leave room
    assign occ    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = (state == RUN) && (occ < 3'd2);

    assign cmd_ready = (state == IDLE);
    assign ram_re    = issue;
    assign ram_ra    = issue ? cur_addr : ra_q;

    assign head     = fifo_mem[rd_ptr];
    assign out_pvld = (fifo_cnt != 2'd0);
    assign out_pd   = head[DW-1:0];
    assign out_last = out_pvld & head[DW];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && remaining == '0) state_nxt = DRAIN;
            DRAIN:   if (pop && out_last && !inflight && fifo_cnt == 2'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            ra_q          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue && (remaining == '0);
            done          <= pop & out_last;
            if (issue) ra_q <= cur_addr;
            if (accept) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SKID; i++) fifo_mem[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {inflight_last, ram_dout};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
        !(push && fifo_cnt == 2'd2 && !pop));

endmodule

// File: tb/tb_sa_ram_rd_stream_32x256.sv
// Directed bench for sa_ram_rd_stream_32x256 with a registered-read RAM model and
// per-word scoreboard checks of address sequence, data order, last/done and backpressure.
module tb_sa_ram_rd_stream_32x256;
    localparam int AW = 5;
    localparam int DW = 256;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_pd;
    logic          out_last;
    logic          done;

    logic [DW-1:0] mem [32];
    int checks = 0;
    int errors = 0;

    sa_ram_rd_stream_32x256 #(.AW(AW), .DW(DW), .SKID(2)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
        .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd),
        .out_last(out_last), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ram_dout = '0;
    always @(posedge clk) if (ram_re) ram_dout <= mem[ram_ra];

    function automatic logic [DW-1:0] mval(input int k);
        logic [31:0] w;
        w = 32'(k);
        return {8{w}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic prdy_for(input int mode, input int cyc);
        case (mode)
            1:       return 1'($urandom_range(0, 1));
            2:       return !(cyc >= 3 && cyc <= 10);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_burst(input int addr, input int len, input int mode,
                             output int first_pop, output int last_pop, output int early_re);
        int iss, idx, lasts, dones, max_occ, unstable, cyc;
        logic [DW-1:0] prev_pd;
        logic prev_hold, fin;
        iss = 0; idx = 0; lasts = 0; dones = 0; max_occ = 0; unstable = 0;
        first_pop = -1; last_pop = -1; early_re = 0;
        prev_pd = '0; prev_hold = 1'b0; fin = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr[AW-1:0];
        cmd_len   = len[AW-1:0];
        out_prdy  = prdy_for(mode, 0);
        @(negedge clk);
        chk("cmd_accept", cmd_ready, 1);
        cyc = 1;
        while (cyc < 300 && !fin) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            out_prdy  = prdy_for(mode, cyc);
            @(negedge clk);
            if (iss - idx > max_occ) max_occ = iss - idx;
            if (prev_hold && out_pd !== prev_pd) unstable++;
            if (ram_re) begin
                chk("ram_ra_seq", ram_ra, (addr + iss) % 32);
                iss++;
                if (cyc <= 10) early_re++;
            end
            if (out_pvld && out_prdy) begin
                chk("stream_pd", out_pd, mem[(addr + idx) % 32]);
                chk("stream_last", out_last, idx == len);
                if (out_last) lasts++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                idx++;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
                chk("done_ready", cmd_ready, 1);
                chk("done_pvld", out_pvld, 0);
            end
            prev_hold = out_pvld && !out_prdy;
            prev_pd   = out_pd;
            cyc++;
        end
        chk("burst_finished", fin, 1);
        chk("word_count", idx, len + 1);
        chk("issue_count", iss, len + 1);
        chk("last_count", lasts, 1);
        chk("done_count", dones, 1);
        chk("occupancy_max", max_occ <= 2, 1);
        chk("pd_stable", unstable, 0);
    endtask

    initial begin
        int fp, lp, er, ra, rl;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_prdy = 1'b0;
        for (int k = 0; k < 32; k++) mem[k] = mval(k);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_ram_ra", ram_ra, 0);
        chk("rst_pvld", out_pvld, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_pd", out_pd, 0);

        // Basic burst addr 3 len 3, cycle-exact
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 5'd3; cmd_len = 5'd3; out_prdy = 1'b1;
        @(negedge clk);
        chk("t1_c0_ready", cmd_ready, 1);
        chk("t1_c0_re", ram_re, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t1_c1_re", ram_re, 1);
        chk("t1_c1_ra", ram_ra, 3);
        chk("t1_c1_ready", cmd_ready, 0);
        @(negedge clk);
        chk("t1_c2_re", ram_re, 1);
        chk("t1_c2_ra", ram_ra, 4);
        chk("t1_c2_pvld", out_pvld, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_pvld", out_pvld, 1);
            chk("t1_pd", out_pd, mval(3 + i));
            chk("t1_last", out_last, i == 3);
            chk("t1_done_low", done, 0);
        end
        @(negedge clk);
        chk("t1_c7_done", done, 1);
        chk("t1_c7_ready", cmd_ready, 1);
        chk("t1_c7_pvld", out_pvld, 0);
        @(negedge clk);
        chk("t1_c8_done", done, 0);

        // Address wrap 30,31,0,1
        run_burst(30, 3, 0, fp, lp, er);
        chk("wrap_first", fp, 3);
        chk("wrap_lastpop", lp, 6);

        // Backpressure: out_prdy low in cycles 3..10
        run_burst(10, 7, 2, fp, lp, er);
        chk("bp_early_reads", er, 2);
        chk("bp_first_pop", fp, 11);
        chk("bp_span", lp - fp, 7);

        // Max burst, full throughput
        run_burst(0, 31, 0, fp, lp, er);
        chk("max_first", fp, 3);
        chk("max_span", lp - fp, 31);

        // Reset in cycle 5 of a 16-word burst
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 5'd8; cmd_len = 5'd15; out_prdy = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_pvld", out_pvld, 1);
        chk("mid_re", ram_re, 1);
        rstn = 1'b0;
        #1;
        chk("arst_ready", cmd_ready, 1);
        chk("arst_re", ram_re, 0);
        chk("arst_ra", ram_ra, 0);
        chk("arst_pvld", out_pvld, 0);
        chk("arst_last", out_last, 0);
        chk("arst_done", done, 0);
        chk("arst_pd", out_pd, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", cmd_ready, 1);
            chk("post_rst_pvld", out_pvld, 0);
            chk("post_rst_re", ram_re, 0);
        end
        run_burst(20, 9, 0, fp, lp, er);
        chk("post_rst_first", fp, 3);

        // Random data, random bursts, random backpressure
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 8; j++) mem[k][j*32 +: 32] = $urandom();
        for (int b = 0; b < 100; b++) begin
            ra = int'($urandom_range(0, 31));
            rl = int'($urandom_range(0, 31));
            run_burst(ra, rl, 1, fp, lp, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_ram_rd_stream_32x256.md
Name: sa_ram_rd_stream_32x256

Overview:
Burst read engine that drives the read port of the 32x256 single-read/single-write SA buffer RAM. It accepts a command holding a start address and a length, issues one RAM read per word, and absorbs the RAM's one-cycle registered-address read latency. It returns the read words on a valid/ready stream, with a last-word marker, to the downstream SA datapath.

Parameters:
AW, 5, RAM address width (32 entries)
DW, 256, RAM data width
SKID, 2, output buffer depth; fixed at 2, other values unsupported

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  engine idle, command accepted on valid&ready
cmd_addr  input  AW  first word address
cmd_len  input  AW  words minus one (0 = 1 word, 31 = 32 words)
ram_ra  output  AW  RAM read address
ram_re  output  1  RAM read enable
ram_dout  input  DW  RAM read data; valid the cycle after ram_re
out_pvld  output  1  stream data valid
out_prdy  input  1  stream data ready
out_pd  output  DW  stream data
out_last  output  1  marks final word of burst, qualified by out_pvld
done  output  1  one-cycle pulse when last word transfers

Behaviour:
- Reset (async assert, sync deassert by the reset tree) forces the following:
  - state IDLE; cmd_ready=1, ram_re=0, ram_ra=0, out_pvld=0, out_last=0, done=0, out_pd=0;
  - skid FIFO, in-flight flag and counters are cleared.
- Reset mid-burst abandons the burst. No partial stream continues after release.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, load cur_addr=cmd_addr and remaining=cmd_len, then go to RUN.
  - RUN: cmd_ready=0. Issue reads subject to credit. When the read with remaining==0 is issued, go to DRAIN.
  - DRAIN: cmd_ready=0. No issues. When in-flight==0, the FIFO is empty and the final word has transferred, go to IDLE.
- Issue rule:
  - Define pop = out_pvld & out_prdy.
  - ram_re=1 in RUN iff (fifo_cnt + inflight - pop) < 2.
  - ram_ra=cur_addr combinationally with ram_re.
  - On issue: cur_addr increments modulo 32 (31 wraps to 0) and remaining decrements.
  - ram_ra holds its last value when ram_re=0.
- Capture:
  - inflight is a 1-bit register, set on issue and cleared the next cycle unless another issue occurs.
  - When inflight=1, {last_flag, ram_dout} is written into the 2-entry skid FIFO in that cycle.
  - last_flag is delayed with the issue.
- Output:
  - out_pvld = fifo_cnt!=0; out_pd/out_last come from the FIFO head (registered storage).
  - Push and pop in the same cycle are legal; fifo_cnt stays unchanged.
  - Overflow is impossible by the credit rule. An assertion fires on push when fifo_cnt==2 & !pop.
- done pulses in the cycle after the handshake on a word with out_last=1. The state returns to IDLE in the same cycle.
- Latency:
  - cmd accepted in cycle 0, ram_re=1 in cycle 1, ram_dout sampled in cycle 2, out_pvld=1 in cycle 3.
  - With out_prdy held high, throughput is 1 word/cycle.
- Backpressure: at most 2 words are buffered or in flight. out_pd is stable while out_pvld & !out_prdy.
- A RAM write to an address already issued but not yet captured returns whatever ram_dout shows in the capture cycle. Avoiding this hazard is the controller's responsibility.
- cmd_valid while busy is ignored (cmd_ready=0). The command must be held by the initiator.

Test Plan:
- Preload M[k]=k replicated; cmd_addr=3, cmd_len=3, out_prdy=1. Required response:
  - out_pd = M[3], M[4], M[5], M[6] on consecutive cycles 3–6;
  - out_last only on M[6];
  - done in cycle 7;
  - cmd_ready=1 again in cycle 7.
- Wrap: cmd_addr=30, cmd_len=3. Required response: ram_ra sequence 30, 31, 0, 1; data M[30], M[31], M[0], M[1].
- Backpressure: cmd_len=7; out_prdy low for cycles 3–10, then high. Required response:
  - ram_re issues exactly 2 reads before stalling;
  - out_pd=M[addr] held stable;
  - all 8 words delivered in order with no loss or duplicate.
- Random out_prdy over 100 bursts of random addr/len. Required response: scoreboard match, exactly one out_last and one done per burst, and the FIFO never exceeds 2.
- Max burst: cmd_addr=0, cmd_len=31, out_prdy=1. Required response: 32 words in 32 consecutive cycles, and ram_ra wraps back to 0 only after 31.
- Reset asserted in cycle 5 of a 16-word burst. Required response:
  - all outputs go immediately to reset values;
  - after release, cmd_ready=1 and no residual out_pvld;
  - a new burst completes correctly.
